// File: rtl/cnt_range_updown.sv
// rtl/cnt_range_updown.sv - WIDTH-bit range counter: up/down/ping-pong/hold, wrap or saturate, load, TC, ERR
// Optional step prescaler is compiled in when CNT_PRESCALE_EN is defined.
module cnt_range_updown #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ss_i,
    input  logic [1:0]       mode_i,
    input  logic             wrap_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic             dir_o,
    output logic             tc_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        MODE_DOWN = 2'b00,
        MODE_UP   = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_param
        $error("cnt_range_updown: WIDTH must be >= 2 and PRESCALE >= 1");
    end

    mode_e            mode;
    logic             range_err;
    logic             tick;
    logic             step;
    logic             out_of_range;
    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] out_dec;
    logic [WIDTH-1:0] load_clamped;

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;

    assign mode      = mode_e'(mode_i);
    assign range_err = (min_i > max_i);

`ifdef CNT_PRESCALE_EN
    localparam int               DIV_W    = $clog2(PRESCALE) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             advance;

    // The divider only runs while the counter could actually step.
    assign advance = ss_i && (mode != MODE_HOLD);
    assign tick    = advance && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = '0;
        end else if (advance) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign step         = ss_i && tick && (mode != MODE_HOLD);
    assign out_of_range = (out_q < min_i) || (out_q > max_i);
    assign out_inc      = out_q + 1'b1;
    assign out_dec      = out_q - 1'b1;
    assign load_clamped = (load_val_i < min_i) ? min_i :
                          (load_val_i > max_i) ? max_i : load_val_i;

    // +/-1 results are only selected after the bound checks, so they never wrap.
    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        err_d = range_err;
        if (!range_err) begin
            if (load_i) begin
                out_d = load_clamped;
            end else if (step) begin
                if (out_of_range) begin
                    out_d = (mode == MODE_DOWN) ? max_i : min_i;
                end else if (min_i == max_i) begin
                    out_d = min_i;
                end else begin
                    case (mode)
                        MODE_UP: begin
                            if (out_q == max_i) begin
                                if (wrap_i) begin
                                    out_d = min_i;
                                    tc_d  = 1'b1;
                                end
                            end else begin
                                out_d = out_inc;
                                tc_d  = !wrap_i && (out_inc == max_i);
                            end
                        end
                        MODE_DOWN: begin
                            if (out_q == min_i) begin
                                if (wrap_i) begin
                                    out_d = max_i;
                                    tc_d  = 1'b1;
                                end
                            end else begin
                                out_d = out_dec;
                                tc_d  = !wrap_i && (out_dec == min_i);
                            end
                        end
                        MODE_PING: begin
                            if (dir_q) begin
                                if (out_q == max_i) begin
                                    dir_d = 1'b0;
                                    out_d = out_dec;
                                    tc_d  = 1'b1;
                                end else begin
                                    out_d = out_inc;
                                end
                            end else begin
                                if (out_q == min_i) begin
                                    dir_d = 1'b1;
                                    out_d = out_inc;
                                    tc_d  = 1'b1;
                                end else begin
                                    out_d = out_dec;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                if (mode == MODE_UP) begin
                    dir_d = 1'b1;
                end else if (mode == MODE_DOWN) begin
                    dir_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            dir_q <= 1'b1;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign out_o = out_q;
    assign dir_o = dir_q;
    assign tc_o  = tc_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_cnt_range_updown.sv
// tb/tb_cnt_range_updown.sv - scoreboard bench for cnt_range_updown (WIDTH=4)
module tb_cnt_range_updown;

    localparam int W  = 4;
    localparam int PS = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ss;
    logic [1:0]   mode;
    logic         wrap;
    logic [W-1:0] mn;
    logic [W-1:0] mx;
    logic         load;
    logic [W-1:0] lval;
    logic [W-1:0] out;
    logic         dir;
    logic         tc;
    logic         err;

    cnt_range_updown #(.WIDTH(W), .PRESCALE(PS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ss_i       (ss),
        .mode_i     (mode),
        .wrap_i     (wrap),
        .min_i      (mn),
        .max_i      (mx),
        .load_i     (load),
        .load_val_i (lval),
        .out_o      (out),
        .dir_o      (dir),
        .tc_o       (tc),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] out;
        logic         dir;
        logic         tc;
        logic         err;
    } exp_t;

    exp_t  sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    string phase = "init";
    int    m_out, m_dir;
`ifdef CNT_PRESCALE_EN
    int    m_div;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, expected %0d", phase, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0;
        m_dir = 1;
`ifdef CNT_PRESCALE_EN
        m_div = 0;
`endif
    endtask

    // Reference behaviour of one clock edge with the inputs currently driven.
    task automatic model_push();
        int   lo, hi, o, d, t, lv;
        bit   tk;
        exp_t e;
`ifdef CNT_PRESCALE_EN
        bit   adv;
`endif
        lo = int'(mn);
        hi = int'(mx);
        lv = int'(lval);
        o  = m_out;
        d  = m_dir;
        t  = 0;
`ifdef CNT_PRESCALE_EN
        adv = ss && (mode != 2'b11);
        tk  = adv && (m_div == PS - 1);
        if (load) m_div = 0;
        else if (adv) m_div = (m_div + 1) % PS;
`else
        tk = 1'b1;
`endif
        if (lo <= hi) begin
            if (load) begin
                o = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
            end else if (ss && mode != 2'b11 && tk) begin
                if (o < lo || o > hi) begin
                    o = (mode == 2'b00) ? hi : lo;
                end else if (lo == hi) begin
                    o = lo;
                end else if (mode == 2'b01) begin
                    if (o < hi) begin
                        o = o + 1;
                        t = (!wrap && o == hi) ? 1 : 0;
                    end else if (wrap) begin
                        o = lo;
                        t = 1;
                    end
                end else if (mode == 2'b00) begin
                    if (o > lo) begin
                        o = o - 1;
                        t = (!wrap && o == lo) ? 1 : 0;
                    end else if (wrap) begin
                        o = hi;
                        t = 1;
                    end
                end else begin
                    if (d == 1 && o == hi) begin d = 0; o = hi - 1; t = 1; end
                    else if (d == 0 && o == lo) begin d = 1; o = lo + 1; t = 1; end
                    else o = (d == 1) ? o + 1 : o - 1;
                end
                if (mode == 2'b01) d = 1;
                if (mode == 2'b00) d = 0;
            end
        end
        m_out = o;
        m_dir = d;
        e.out = W'(o);
        e.dir = (d != 0);
        e.tc  = (t != 0);
        e.err = (lo > hi);
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out", out, e.out);
            check("dir", dir, e.dir);
            check("tc",  tc,  e.tc);
            check("err", err, e.err);
        end
    endtask

    initial begin
        rst_n = 1'b0; ss = 1'b0; mode = 2'b01; wrap = 1'b1;
        mn = '0; mx = 4'd15; load = 1'b0; lval = '0;
        model_reset();

        #12;
        phase = "por";
        check("out", out, 0);
        check("dir", dir, 1);
        check("tc",  tc,  0);
        check("err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reach OUT=7 counting down (DIR=0), then reset between edges
        phase = "midreset";
        load = 1'b1; lval = 4'd8; cyc();
        load = 1'b0; ss = 1'b1; mode = 2'b00; cyc();
        #2 rst_n = 1'b0;
        #1;
        check("out_async", out, 0);
        check("dir_async", dir, 1);
        check("tc_async",  tc,  0);
        model_reset();
        #2 rst_n = 1'b1;

        phase = "up_wrap";
        mode = 2'b01; wrap = 1'b1; mn = 4'd3; mx = 4'd6; ss = 1'b1;
        repeat (7) cyc();

        phase = "up_sat";
        wrap = 1'b0; mn = 4'd0; mx = 4'd15;
        repeat (16) cyc();
        phase = "down_after_sat";
        mode = 2'b00;
        repeat (4) cyc();

        phase = "pingpong";
        mode = 2'b10; mn = 4'd2; mx = 4'd5;
        repeat (12) cyc();

        phase = "load";
        ss = 1'b0; load = 1'b1; lval = 4'd12; mn = 4'd2; mx = 4'd9; cyc();
        ss = 1'b1; mode = 2'b01; lval = 4'd3; cyc();
        lval = 4'd0; cyc();
        mode = 2'b11; lval = 4'd6; cyc();
        load = 1'b0; cyc();

        phase = "err";
        mode = 2'b01; mn = 4'd8; mx = 4'd4;
        repeat (2) cyc();
        load = 1'b1; lval = 4'd5; cyc();
        load = 1'b0; mn = 4'd0; mx = 4'd15; cyc();

        phase = "down_wrap";
        mode = 2'b00; wrap = 1'b1; load = 1'b1; lval = 4'd1; cyc();
        load = 1'b0;
        repeat (4) cyc();

        phase = "hold_stop";
        mode = 2'b11; repeat (2) cyc();
        mode = 2'b01; ss = 1'b0; repeat (2) cyc();

        phase = "min_eq_max";
        ss = 1'b1; mn = 4'd5; mx = 4'd5;
        repeat (3) cyc();
        mode = 2'b10; repeat (2) cyc();

        phase = "prescale_run";
        mode = 2'b01; wrap = 1'b1; mn = 4'd0; mx = 4'd15;
        repeat (12) cyc();

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            ss   = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            wrap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                mn = 4'($urandom_range(0, 15));
                mx = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0 && mn > mx) begin
                    lval = mn; mn = mx; mx = lval;
                end
            end
            load = ($urandom_range(0, 15) == 0);
            lval = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
